// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signal bundle for dmem_arbiter
interface dmem_arbiter_if;
    logic        req0;
    logic        req1;
    logic [63:0] addr0;
    logic [63:0] addr1;
    logic [63:0] wdata0;
    logic [63:0] wdata1;
    logic        wwe0;
    logic        wwe1;
    logic        bwe0;
    logic        bwe1;
    logic        lock1;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [63:0] rdata0;
    logic [63:0] rdata1;
    logic        err0;
    logic        err1;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_word_we;
    logic        mem_byte_we;
    logic [63:0] mem_rdata;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1,
        input  wwe0, wwe1, bwe0, bwe1, lock1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mem_addr, mem_wdata, mem_word_we, mem_byte_we
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1,
        output wwe0, wwe1, bwe0, bwe1, lock1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mem_addr, mem_wdata, mem_word_we, mem_byte_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with starvation guard and locked bursts
module dmem_arbiter #(
    parameter logic [63:0] DATA_START = 64'h10000000,
    parameter logic [63:0] DATA_WORDS = 64'h10000,
    parameter int          MAX_WAIT   = 4,
    parameter int          MAX_BURST  = 8
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int              WW        = $clog2(MAX_WAIT + 1);
    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0]   WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
    localparam logic [64:0]     DATA_END  = {1'b0, DATA_START} + {1'b0, DATA_WORDS};

    logic [WW-1:0] wait_cnt;
    logic [BW-1:0] burst_cnt;
    logic          prev_gnt1;

    logic          gnt0;
    logic          gnt1;
    logic          locked;
    logic          starved;
    logic          burst_block;

    logic [63:0]   sel_addr;
    logic [63:0]   sel_wdata;
    logic          sel_wwe;
    logic          sel_bwe;
    logic          in_range;
    logic [63:0]   resp_data;

    logic          rvalid0_q;
    logic          rvalid1_q;
    logic          err0_q;
    logic          err1_q;
    logic [63:0]   rdata0_q;
    logic [63:0]   rdata1_q;

    always_comb begin
        locked      = prev_gnt1 && bus.lock1 && bus.req1 && (burst_cnt < BURST_MAX);
        // A full burst yields to a waiting port 0 even over the starvation rule
        burst_block = (burst_cnt == BURST_MAX) && bus.req0;
        starved     = bus.req1 && (wait_cnt == WAIT_MAX) && !burst_block;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        if (!reset) begin
            if (locked || starved) begin
                gnt1 = 1'b1;
            end else if (bus.req0) begin
                gnt0 = 1'b1;
            end else if (bus.req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wwe   = 1'b0;
        sel_bwe   = 1'b0;
        if (gnt0) begin
            sel_addr  = bus.addr0;
            sel_wdata = bus.wdata0;
            sel_wwe   = bus.wwe0;
            sel_bwe   = bus.bwe0;
        end else if (gnt1) begin
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
            sel_wwe   = bus.wwe1;
            sel_bwe   = bus.bwe1;
        end
    end

    // 65-bit compares so a segment ending at 2^64 does not wrap
    assign in_range  = ({1'b0, sel_addr} >= {1'b0, DATA_START}) && ({1'b0, sel_addr} < DATA_END);
    assign resp_data = (in_range && !sel_wwe && !sel_bwe) ? bus.mem_rdata : 64'h0;

    assign bus.gnt0        = gnt0;
    assign bus.gnt1        = gnt1;
    assign bus.mem_addr    = sel_addr;
    assign bus.mem_wdata   = sel_wdata;
    assign bus.mem_word_we = sel_wwe && in_range && !reset;
    assign bus.mem_byte_we = sel_bwe && !sel_wwe && in_range && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            burst_cnt <= '0;
            prev_gnt1 <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            prev_gnt1 <= gnt1;
            if (gnt1 || !bus.req1) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // Saturates so an over-long locked stream keeps deferring to port 0
            if (!gnt1) begin
                burst_cnt <= '0;
            end else if (prev_gnt1 && bus.lock1) begin
                if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                burst_cnt <= BW'(1);
            end
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
            err0_q    <= gnt0 && !in_range;
            err1_q    <= gnt1 && !in_range;
            if (gnt0) begin
                rdata0_q <= resp_data;
            end
            if (gnt1) begin
                rdata1_q <= resp_data;
            end
        end
    end

    // A response landing while reset is held is suppressed at the output
    assign bus.rvalid0 = rvalid0_q && !reset;
    assign bus.rvalid1 = rvalid1_q && !reset;
    assign bus.err0    = err0_q && !reset;
    assign bus.err1    = err1_q && !reset;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
endmodule
